// File: rtl/dtree_walk_ctrl_if.sv
// Sample, result and node-table config signals of the decision-tree walker.
interface dtree_walk_ctrl_if #(
  parameter int NFEAT = 5,
  parameter int FW    = 8,
  parameter int AW    = 6,
  parameter int CW    = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NFEAT*FW-1:0]   in_feat;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_class;
  logic [5:0]            out_depth;
  logic                  out_err;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [26:0]           cfg_data;
  logic                  busy;

  modport master (
    output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_depth, out_err, busy
  );

  modport slave (
    input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_depth, out_err, busy
  );
endinterface

// File: rtl/dtree_walk_ctrl.sv
// Sequential decision-tree evaluator: one shared comparator walks a
// programmable node table, one node per FETCH/EVAL pair.
//
// state | meaning
// IDLE  | waiting for a sample; node table writable
// FETCH | reading node[addr] into the node register
// EVAL  | compare / leaf / abort decision on the fetched node
// DONE  | result presented, waiting for out_ready
module dtree_walk_ctrl #(
  parameter int NFEAT     = 5,
  parameter int FW        = 8,
  parameter int AW        = 6,
  parameter int CW        = 6,
  parameter int MAX_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  dtree_walk_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] NF_LIM  = 4'(NFEAT);
  localparam logic [5:0] D_LIM   = 6'(MAX_DEPTH);

  logic [1:0]          state;
  logic [NFEAT*FW-1:0] feat_q;
  logic [AW-1:0]       addr;
  logic [5:0]          depth;
  logic [26:0]         node_q;
  logic [CW-1:0]       class_q;
  logic [5:0]          depth_q;
  logic                err_q;

  logic [26:0]         tbl [2**AW];

  logic                n_leaf;
  logic [2:0]          n_fsel;
  logic [2:0]          n_nb;
  logic [7:0]          n_thr;
  logic [AW-1:0]       n_left;
  logic [AW-1:0]       n_right;

  logic [FW-1:0]       feat_arr [8];
  logic [7:0]          sel_val;
  logic [7:0]          cmp_val;
  logic [2:0]          shamt;
  logic [AW-1:0]       child;
  logic                bad_sel;

  assign n_leaf  = node_q[26];
  assign n_fsel  = node_q[25:23];
  assign n_nb    = node_q[22:20];
  assign n_thr   = node_q[19:12];
  assign n_left  = node_q[11:6];
  assign n_right = node_q[5:0];

  // Unpack features into an 8-entry array; selects past NFEAT read zero
  // but are rejected as errors before the comparison result is used.
  always_comb begin
    for (int i = 0; i < 8; i++) feat_arr[i] = '0;
    for (int i = 0; i < NFEAT; i++) feat_arr[i] = feat_q[i*FW +: FW];
  end

  // Shared comparator: top (nb+1) bits of the feature against the threshold.
  always_comb begin
    sel_val = feat_arr[n_fsel];
    shamt   = 3'd7 - n_nb;
    cmp_val = sel_val >> shamt;
    child   = (cmp_val <= n_thr) ? n_left : n_right;
    bad_sel = ({1'b0, n_fsel} >= NF_LIM);
  end

  // Node table: writes only land while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && state == S_IDLE) tbl[bus.cfg_addr] <= bus.cfg_data;
  end

  // Walk FSM and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      feat_q  <= '0;
      addr    <= '0;
      depth   <= '0;
      node_q  <= '0;
      class_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            feat_q <= bus.in_feat;
            addr   <= '0;
            depth  <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          node_q <= tbl[addr];
          state  <= S_EVAL;
        end
        S_EVAL: begin
          if (n_leaf) begin
            class_q <= n_thr[CW-1:0];
            err_q   <= 1'b0;
            depth_q <= depth;
            state   <= S_DONE;
          end else if (bad_sel || depth == D_LIM) begin
            class_q <= '0;
            err_q   <= 1'b1;
            depth_q <= depth;
            state   <= S_DONE;
          end else begin
            addr  <= child;
            depth <= depth + 6'd1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_class = class_q;
  assign bus.out_depth = depth_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_dtree_walk_ctrl.sv
// Self-checking bench for dtree_walk_ctrl with a behavioural tree-walk model.
module tb_dtree_walk_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [26:0] tbl [64];

  dtree_walk_ctrl_if #(.NFEAT(5), .FW(8), .AW(6), .CW(6)) bus_i ();

  dtree_walk_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] mk_leaf(input int c);
    logic [26:0] w;
    w = '0;
    w[26] = 1'b1;
    w[19:12] = 8'(c);
    return w;
  endfunction

  function automatic logic [26:0] mk_node(input int fs, input int nb, input int thr,
                                          input int l, input int r);
    logic [26:0] w;
    w = {1'b0, 3'(fs), 3'(nb), 8'(thr), 6'(l), 6'(r)};
    return w;
  endfunction

  // Reference walk straight from the node-format rules.
  function automatic void model(input logic [39:0] f, output int cls,
                                output int dep, output int err);
    int a, fs, nb, thr, x, v;
    bit fin;
    logic [26:0] nd;
    a = 0; dep = 0; cls = 0; err = 0; fin = 0;
    while (!fin) begin
      nd  = tbl[a];
      fs  = int'(nd[25:23]);
      nb  = int'(nd[22:20]);
      thr = int'(nd[19:12]);
      if (nd[26]) begin
        cls = thr % 64;
        fin = 1;
      end else if (fs >= 5 || dep == 32) begin
        err = 1;
        fin = 1;
      end else begin
        x = int'(f[fs*8 +: 8]);
        v = x / (1 << (7 - nb));
        a = (v <= thr) ? int'(nd[11:6]) : int'(nd[5:0]);
        dep++;
      end
    end
  endfunction

  task automatic cfg_write(input int a, input logic [26:0] d);
    bus_i.cfg_addr = 6'(a);
    bus_i.cfg_data = d;
    bus_i.cfg_we   = 1'b1;
    tick();
    bus_i.cfg_we   = 1'b0;
    tbl[a] = d;
  endtask

  task automatic load_tree();
    cfg_write(0, mk_node(0, 1, 0, 1, 2));
    cfg_write(1, mk_leaf(42));
    cfg_write(2, mk_leaf(17));
  endtask

  // Accepts one sample; returns the cycle out_valid rose (-1 if never).
  task automatic run_sample(input logic [39:0] feat, output int lat);
    int w;
    lat = -1;
    w = 0;
    while (!bus_i.in_ready && w < 100) begin tick(); w++; end
    bus_i.in_feat  = feat;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    bus_i.in_feat  = {8'($urandom), 32'($urandom)};
    for (int n = 1; n <= 200; n++) begin
      if (bus_i.out_valid) begin lat = n; break; end
      tick();
    end
  endtask

  task automatic handshake();
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus_i.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus_i.in_ready); end
    checks++;
    if (bus_i.out_valid !== 1'b0 || bus_i.busy !== 1'b0) begin errors++;
      $display("FAIL reset_valid_busy got %0b/%0b want 0/0", bus_i.out_valid, bus_i.busy); end
    checks++;
    if (bus_i.out_class !== 6'd0 || bus_i.out_depth !== 6'd0 || bus_i.out_err !== 1'b0) begin errors++;
      $display("FAIL reset_outputs got %0d/%0d/%0b want 0/0/0", bus_i.out_class, bus_i.out_depth, bus_i.out_err); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus_i.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", bus_i.in_ready); end
  endtask

  task automatic test_basic();
    logic [39:0] feats [2];
    int exp_cls [2];
    int lat;
    feats[0] = 40'h20; exp_cls[0] = 42;
    feats[1] = 40'h40; exp_cls[1] = 17;
    load_tree();
    for (int i = 0; i < 2; i++) begin
      run_sample(feats[i], lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 5", i, lat); end
      checks++;
      if (bus_i.out_class !== 6'(exp_cls[i]) || bus_i.out_depth !== 6'd1 || bus_i.out_err !== 1'b0) begin errors++;
        $display("FAIL basic_result[%0d] got %0d/%0d/%0b want %0d/1/0", i, bus_i.out_class, bus_i.out_depth,
                 bus_i.out_err, exp_cls[i]); end
      handshake();
      checks++;
      if (bus_i.out_valid !== 1'b0 || bus_i.in_ready !== 1'b1) begin errors++;
        $display("FAIL basic_release[%0d] got valid %0b ready %0b want 0/1", i, bus_i.out_valid, bus_i.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit held_ok;
    run_sample(40'h20, lat);
    checks++;
    if (lat !== 5 || bus_i.out_class !== 6'd42) begin errors++;
      $display("FAIL bp_first got lat %0d class %0d want 5/42", lat, bus_i.out_class); end
    bus_i.in_feat  = 40'h40;
    bus_i.in_valid = 1'b1;
    held_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (bus_i.out_valid !== 1'b1 || bus_i.out_class !== 6'd42 || bus_i.out_depth !== 6'd1 ||
          bus_i.in_ready !== 1'b0) held_ok = 0;
      tick();
    end
    checks++;
    if (!held_ok) begin errors++; $display("FAIL bp_hold got unstable outputs want stable class 42 and in_ready 0"); end
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    checks++;
    if (bus_i.busy !== 1'b0 || bus_i.in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_no_overlap got busy %0b ready %0b want 0/1", bus_i.busy, bus_i.in_ready); end
    tick();
    bus_i.in_valid = 1'b0;
    checks++;
    if (bus_i.busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy %0b want 1", bus_i.busy); end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (bus_i.out_valid) begin lat = n; break; end
      tick();
    end
    checks++;
    if (lat !== 5 || bus_i.out_class !== 6'd17) begin errors++;
      $display("FAIL bp_second got lat %0d class %0d want 5/17", lat, bus_i.out_class); end
    handshake();
  endtask

  task automatic test_selfloop();
    int lat;
    cfg_write(0, mk_node(0, 7, 0, 0, 0));
    run_sample(40'h55, lat);
    checks++;
    if (lat !== 67) begin errors++; $display("FAIL selfloop_latency got %0d want 67", lat); end
    checks++;
    if (bus_i.out_err !== 1'b1 || bus_i.out_class !== 6'd0 || bus_i.out_depth !== 6'd32) begin errors++;
      $display("FAIL selfloop_result got err %0b class %0d depth %0d want 1/0/32", bus_i.out_err,
               bus_i.out_class, bus_i.out_depth); end
    handshake();
  endtask

  task automatic test_badfeat();
    int lat;
    cfg_write(0, mk_node(6, 7, 0, 1, 2));
    run_sample(40'h12_3456_789a, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL badfeat_latency got %0d want 3", lat); end
    checks++;
    if (bus_i.out_err !== 1'b1 || bus_i.out_class !== 6'd0 || bus_i.out_depth !== 6'd0) begin errors++;
      $display("FAIL badfeat_result got err %0b class %0d depth %0d want 1/0/0", bus_i.out_err,
               bus_i.out_class, bus_i.out_depth); end
    handshake();
    load_tree();
  endtask

  task automatic test_cfg_during_walk();
    int lat;
    bus_i.in_feat  = 40'h20;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    bus_i.cfg_addr = 6'd1;
    bus_i.cfg_data = mk_leaf(5);
    bus_i.cfg_we   = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (bus_i.out_valid) begin lat = n; break; end
      tick();
    end
    tick();
    bus_i.cfg_we = 1'b0;
    checks++;
    if (lat !== 5 || bus_i.out_class !== 6'd42) begin errors++;
      $display("FAIL cfg_dropped got lat %0d class %0d want 5/42", lat, bus_i.out_class); end
    handshake();
    cfg_write(1, mk_leaf(5));
    run_sample(40'h20, lat);
    checks++;
    if (bus_i.out_class !== 6'd5) begin errors++; $display("FAIL cfg_idle_write got %0d want 5", bus_i.out_class); end
    handshake();
    bus_i.cfg_addr = 6'd1;
    bus_i.cfg_data = mk_leaf(33);
    bus_i.cfg_we   = 1'b1;
    bus_i.in_feat  = 40'h20;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.cfg_we   = 1'b0;
    bus_i.in_valid = 1'b0;
    tbl[1] = mk_leaf(33);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      if (bus_i.out_valid) begin lat = n; break; end
      tick();
    end
    checks++;
    if (lat !== 5 || bus_i.out_class !== 6'd33) begin errors++;
      $display("FAIL cfg_same_cycle got lat %0d class %0d want 5/33", lat, bus_i.out_class); end
    handshake();
    cfg_write(1, mk_leaf(42));
  endtask

  task automatic test_reset_midwalk();
    int lat;
    bit quiet;
    bus_i.in_feat  = 40'h20;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus_i.in_ready !== 1'b0 || bus_i.busy !== 1'b0 || bus_i.out_valid !== 1'b0) begin errors++;
      $display("FAIL midwalk_rst got ready %0b busy %0b valid %0b want 0/0/0", bus_i.in_ready,
               bus_i.busy, bus_i.out_valid); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus_i.in_ready !== 1'b1) begin errors++; $display("FAIL midwalk_ready got %0b want 1", bus_i.in_ready); end
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      if (bus_i.out_valid !== 1'b0) quiet = 0;
      tick();
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL midwalk_no_result got out_valid high want low"); end
    run_sample(40'h20, lat);
    checks++;
    if (lat !== 5 || bus_i.out_class !== 6'd42 || bus_i.out_err !== 1'b0) begin errors++;
      $display("FAIL midwalk_rerun got lat %0d class %0d err %0b want 5/42/0", lat, bus_i.out_class, bus_i.out_err); end
    handshake();
  endtask

  task automatic test_random();
    int lat, ecls, edep, eerr, fs;
    logic [39:0] f;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 64; a++) begin
        if ($urandom_range(3) == 0 && a != 0) cfg_write(a, mk_leaf(int'($urandom_range(63))));
        else begin
          fs = ($urandom_range(9) == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4));
          cfg_write(a, mk_node(fs, int'($urandom_range(7)), int'($urandom_range(255)),
                               int'($urandom_range(63)), int'($urandom_range(63))));
        end
      end
      for (int s = 0; s < 10; s++) begin
        f = {8'($urandom), 32'($urandom)};
        model(f, ecls, edep, eerr);
        run_sample(f, lat);
        checks++;
        if (lat !== 2*edep + 3) begin errors++;
          $display("FAIL rand_latency[%0d.%0d] got %0d want %0d", t, s, lat, 2*edep + 3); end
        checks++;
        if (bus_i.out_class !== 6'(ecls) || bus_i.out_depth !== 6'(edep) || bus_i.out_err !== 1'(eerr)) begin
          errors++;
          $display("FAIL rand_result[%0d.%0d] got %0d/%0d/%0b want %0d/%0d/%0d", t, s, bus_i.out_class,
                   bus_i.out_depth, bus_i.out_err, ecls, edep, eerr);
        end
        repeat ($urandom_range(2)) tick();
        handshake();
        checks++;
        if (bus_i.in_ready !== 1'b1) begin errors++;
          $display("FAIL rand_release[%0d.%0d] got %0b want 1", t, s, bus_i.in_ready); end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus_i.in_valid  = 1'b0;
    bus_i.in_feat   = '0;
    bus_i.out_ready = 1'b0;
    bus_i.cfg_we    = 1'b0;
    bus_i.cfg_addr  = '0;
    bus_i.cfg_data  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_selfloop();
    test_badfeat();
    test_cfg_during_walk();
    test_reset_midwalk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
